dram_result_uart_framer: RTL and testbench

- Captures one snapshot of all per-core DRAM read results on each read-done event.
- Streams the snapshot as a framed, checksummed byte sequence through the existing uart_send transmitter. Frame layout: header, sequence number, count, payload, XOR checksum.
- Parametrised in channel count and result width. Per-channel enable mask selects which cores are sent.
- Sits between DRAM_write_read_16core outputs and uart_send in the board-level test top.

---
 rtl/dram_io_pkg.sv | 36 +++
 rtl/dram_result_uart_framer_handshake.sv | 107 ++++++++++
 rtl/dram_result_uart_framer.sv | 213 +++++++++++++++++++++
 tb/tb_dram_result_uart_framer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_io_pkg.sv
// Shared definitions for the DRAM result framer slice.
//   frame_state_t : states of the framer and of its byte handshake
//   frame_phase_t : which part of the frame the byte pointer is on
//   DEF_HDR_BYTE  : default frame start byte
//   clog2()       : constant ceiling-log2 for pointer widths
package dram_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_NEXT,
    ST_DONE
  } frame_state_t;

  typedef enum logic [2:0] {
    PH_HDR,
    PH_SEQ,
    PH_CNT,
    PH_PAY,
    PH_CHK
  } frame_phase_t;

  localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dram_result_uart_framer_handshake.sv
// One-byte handshake towards uart_send.
// Ports:
//   clk_100m, rst_n  : clock, async active-low reset
//   start, byte_in   : request to send byte_in (one-cycle pulse)
//   uart_busy        : transmitter busy
//   uart_en/uart_din : registered start pulse and held byte to uart_send
//   byte_done        : one-cycle pulse when the byte has been taken
//
// Handshake: a byte is issued (uart_en=1 for one cycle) only in a cycle
// that follows a cycle with uart_busy=0. After issue we wait for busy to
// rise (WAIT_HI) and then fall (WAIT_LO). If busy never rises within
// BUSY_TO cycles the byte is considered sent, so a silent transmitter
// cannot hang the frame.
module uart_byte_handshake
  import dram_io_pkg::*;
#(
  parameter int BUSY_TO = 15
) (
  input  logic       clk_100m,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       uart_busy,
  output logic       uart_en,
  output logic [7:0] uart_din,
  output logic       byte_done
);

  localparam int TW = clog2(BUSY_TO) + 1;

  frame_state_t  state, state_next;
  logic [TW-1:0] tmo_cnt, tmo_next;
  logic [7:0]    hold, hold_next, din_next;
  logic          en_next, done_next;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      hold      <= '0;
      uart_din  <= '0;
      uart_en   <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      tmo_cnt   <= tmo_next;
      hold      <= hold_next;
      uart_din  <= din_next;
      uart_en   <= en_next;
      byte_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    tmo_next   = tmo_cnt;
    hold_next  = hold;
    din_next   = uart_din;
    en_next    = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          hold_next = byte_in;
          if (!uart_busy) begin
            din_next   = byte_in;
            en_next    = 1'b1;
            tmo_next   = '0;
            state_next = ST_WAIT_HI;
          end else begin
            // Previous byte still draining: park it until busy drops.
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (!uart_busy) begin
          din_next   = hold;
          en_next    = 1'b1;
          tmo_next   = '0;
          state_next = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (uart_busy) begin
          state_next = ST_WAIT_LO;
        end else if (tmo_cnt == TW'(BUSY_TO - 1)) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tmo_next = tmo_cnt + TW'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!uart_busy) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/dram_result_uart_framer.sv
// Snapshots all per-core DRAM read results on a rd_done rising edge and
// streams them to uart_send as: HDR, seq, count, payload, chk.
// chk is the XOR of seq, count and every payload byte.
// Ports:
//   clk_100m, rst_n      : clock, async active-low reset
//   rd_done              : read complete; rising edge triggers capture
//   dram_data            : channel i at [i*DW +: DW]
//   ch_mask              : bit i includes channel i (sampled at capture)
//   uart_busy            : transmitter busy
//   uart_en, uart_din    : one-cycle start pulse and byte to uart_send
//   frame_busy           : high from capture until the frame is finished
//   frame_done           : one-cycle pulse at the end of a frame
//   seq                  : sequence number of the last captured frame
//   drop_cnt             : saturating count of triggers seen while busy
module dram_result_uart_framer
  import dram_io_pkg::*;
#(
  parameter int         NUM_CH   = 16,
  parameter int         DW       = 8,
  parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE,
  parameter int         BUSY_TO  = 15
) (
  input  logic                 clk_100m,
  input  logic                 rst_n,
  input  logic                 rd_done,
  input  logic [NUM_CH*DW-1:0] dram_data,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic                 uart_busy,
  output logic                 uart_en,
  output logic [7:0]           uart_din,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic [7:0]           seq,
  output logic [7:0]           drop_cnt
);

  localparam int NB  = DW / 8;
  localparam int CPW = clog2(NUM_CH) + 1;
  localparam int BPW = clog2(NB) + 1;

  if ((DW % 8) != 0 || NUM_CH < 1 || NUM_CH > 32) begin : g_param_check
    $error("dram_result_uart_framer: DW must be a multiple of 8 and NUM_CH in 1..32");
  end

  // The framer spends the whole handshake in ST_WAIT_HI waiting for
  // byte_done; the busy-high / busy-low split lives in the handshake.
  frame_state_t            state, state_next;
  frame_phase_t            phase, phase_adv;
  logic [CPW-1:0]          ch_ptr, ch_adv, first_ch, after_ch;
  logic [BPW-1:0]          bptr, b_adv;
  logic                    has_first, has_after;
  logic [NUM_CH*DW-1:0]    snap_data;
  logic [NUM_CH-1:0]       snap_mask;
  logic [7:0]              count_q, mask_pop, chk_acc, cur_byte, pay_byte;
  logic [DW-1:0]           cur_word;
  logic                    rd_done_q, trigger, hs_start, byte_done;

  assign trigger = rd_done & ~rd_done_q;

  uart_byte_handshake #(.BUSY_TO(BUSY_TO)) u_handshake (
    .clk_100m  (clk_100m),
    .rst_n     (rst_n),
    .start     (hs_start),
    .byte_in   (cur_byte),
    .uart_busy (uart_busy),
    .uart_en   (uart_en),
    .uart_din  (uart_din),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    hs_start   = 1'b0;
    case (state)
      ST_IDLE:    if (trigger) state_next = ST_LOAD;
      ST_LOAD: begin
        hs_start   = 1'b1;
        state_next = ST_WAIT_HI;
      end
      ST_WAIT_HI: if (byte_done) state_next = ST_NEXT;
      ST_NEXT:    state_next = (phase == PH_CHK) ? ST_DONE : ST_LOAD;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Live mask popcount, captured together with the mask.
  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < NUM_CH; i++) mask_pop = mask_pop + 8'(ch_mask[i]);
  end

  // Lowest enabled channel overall, and lowest enabled channel above ch_ptr.
  always_comb begin
    has_first = 1'b0;
    first_ch  = '0;
    has_after = 1'b0;
    after_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (snap_mask[i]) begin
        has_first = 1'b1;
        first_ch  = CPW'(i);
        if (i > int'(ch_ptr)) begin
          has_after = 1'b1;
          after_ch  = CPW'(i);
        end
      end
    end
  end

  // Byte currently pointed at; payload goes MSB byte first.
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch_ptr) == i) cur_word = snap_data[i*DW +: DW];
    end
    pay_byte = '0;
    for (int b = 0; b < NB; b++) begin
      if (int'(bptr) == b) pay_byte = cur_word[(NB-1-b)*8 +: 8];
    end
    case (phase)
      PH_HDR:  cur_byte = HDR_BYTE;
      PH_SEQ:  cur_byte = seq;
      PH_CNT:  cur_byte = count_q;
      PH_PAY:  cur_byte = pay_byte;
      PH_CHK:  cur_byte = chk_acc;
      default: cur_byte = '0;
    endcase
  end

  // Pointer advance applied in ST_NEXT.
  always_comb begin
    phase_adv = phase;
    ch_adv    = ch_ptr;
    b_adv     = bptr;
    case (phase)
      PH_HDR: phase_adv = PH_SEQ;
      PH_SEQ: phase_adv = PH_CNT;
      PH_CNT: begin
        if (has_first) begin
          phase_adv = PH_PAY;
          ch_adv    = first_ch;
          b_adv     = '0;
        end else begin
          phase_adv = PH_CHK;
        end
      end
      PH_PAY: begin
        if (bptr == BPW'(NB - 1)) begin
          if (has_after) begin
            ch_adv = after_ch;
            b_adv  = '0;
          end else begin
            phase_adv = PH_CHK;
          end
        end else begin
          b_adv = bptr + BPW'(1);
        end
      end
      default: phase_adv = phase;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rd_done_q  <= 1'b0;
      snap_data  <= '0;
      snap_mask  <= '0;
      count_q    <= '0;
      chk_acc    <= '0;
      phase      <= PH_HDR;
      ch_ptr     <= '0;
      bptr       <= '0;
      seq        <= '0;
      drop_cnt   <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd_done_q  <= rd_done;
      frame_done <= 1'b0;
      if (state == ST_IDLE && trigger) begin
        snap_data  <= dram_data;
        snap_mask  <= ch_mask;
        count_q    <= mask_pop;
        seq        <= seq + 8'd1;
        frame_busy <= 1'b1;
        chk_acc    <= '0;
        phase      <= PH_HDR;
        ch_ptr     <= '0;
        bptr       <= '0;
      end
      if (state != ST_IDLE && trigger && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      if (state == ST_LOAD && phase inside {PH_SEQ, PH_CNT, PH_PAY}) begin
        chk_acc <= chk_acc ^ cur_byte;
      end
      if (state == ST_NEXT) begin
        phase  <= phase_adv;
        ch_ptr <= ch_adv;
        bptr   <= b_adv;
        if (phase == PH_CHK) frame_done <= 1'b1;
      end
      if (state == ST_DONE) frame_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_result_uart_framer.sv
// Bench for dram_result_uart_framer: a 16x8 instance and a 2x16 instance,
// each with a uart_send stand-in whose busy lags uart_en by two cycles.
// Expected bytes are queued when a trigger is driven and popped as the
// DUT issues uart_en.
module tb_dram_result_uart_framer;

  localparam int NUM_CH  = 16;
  localparam int DW      = 8;
  localparam int BUSY_TO = 15;

  logic clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;
  logic rst_n;

  logic                 rd_done;
  logic [NUM_CH*DW-1:0] dram_data;
  logic [NUM_CH-1:0]    ch_mask;
  logic                 uart_busy, uart_en, frame_busy, frame_done;
  logic [7:0]           uart_din, seq, drop_cnt;

  logic        w_rd_done;
  logic [31:0] w_dram_data;
  logic [1:0]  w_ch_mask;
  logic        w_uart_busy, w_uart_en, w_frame_busy, w_frame_done;
  logic [7:0]  w_uart_din, w_seq, w_drop_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int w_done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] w_exp_q[$];
  int en_cyc_q[$];
  logic [7:0] exp_b, w_exp_b;
  logic stub_dead;
  int busy_left, w_busy_left;
  logic en_q, w_en_q;

  dram_result_uart_framer #(.NUM_CH(NUM_CH), .DW(DW), .HDR_BYTE(8'hA5), .BUSY_TO(BUSY_TO)) u_dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .rd_done(rd_done), .dram_data(dram_data),
    .ch_mask(ch_mask), .uart_busy(uart_busy), .uart_en(uart_en), .uart_din(uart_din),
    .frame_busy(frame_busy), .frame_done(frame_done), .seq(seq), .drop_cnt(drop_cnt)
  );

  dram_result_uart_framer #(.NUM_CH(2), .DW(16), .HDR_BYTE(8'hA5), .BUSY_TO(BUSY_TO)) u_wide (
    .clk_100m(clk_100m), .rst_n(rst_n), .rd_done(w_rd_done), .dram_data(w_dram_data),
    .ch_mask(w_ch_mask), .uart_busy(w_uart_busy), .uart_en(w_uart_en), .uart_din(w_uart_din),
    .frame_busy(w_frame_busy), .frame_done(w_frame_done), .seq(w_seq), .drop_cnt(w_drop_cnt)
  );

  // ---------------- clock/reset bookkeeping and uart stand-ins ----------------
  always @(posedge clk_100m) cyc <= cyc + 1;

  always @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0; busy_left <= 0;
      w_en_q <= 1'b0; w_busy_left <= 0;
    end else begin
      en_q   <= uart_en;
      w_en_q <= w_uart_en;
      if (en_q && !stub_dead) busy_left <= int'($urandom_range(2, 6));
      else if (busy_left > 0) busy_left <= busy_left - 1;
      if (w_en_q) w_busy_left <= int'($urandom_range(2, 6));
      else if (w_busy_left > 0) w_busy_left <= w_busy_left - 1;
    end
  end
  assign uart_busy   = (busy_left != 0);
  assign w_uart_busy = (w_busy_left != 0);

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk_100m) begin
    if (rst_n) begin
      if (uart_en) begin
        en_cyc_q.push_back(cyc);
        vectors++;
        if (uart_busy !== 1'b0) begin
          miscompares++;
          $display("FAIL en_while_busy: uart_busy=%b required 0 at cycle %0d", uart_busy, cyc);
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_byte: got %02h, required no byte", uart_din);
        end else begin
          exp_b = exp_q.pop_front();
          if (uart_din !== exp_b) begin
            miscompares++;
            $display("FAIL byte: got %02h, required %02h at cycle %0d", uart_din, exp_b, cyc);
          end
        end
      end
      if (frame_done) done_cnt++;
      if (w_uart_en) begin
        vectors++;
        if (w_uart_busy !== 1'b0) begin
          miscompares++;
          $display("FAIL w_en_while_busy: uart_busy=%b required 0", w_uart_busy);
        end
        vectors++;
        if (w_exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL w_unexpected_byte: got %02h, required no byte", w_uart_din);
        end else begin
          w_exp_b = w_exp_q.pop_front();
          if (w_uart_din !== w_exp_b) begin
            miscompares++;
            $display("FAIL w_byte: got %02h, required %02h", w_uart_din, w_exp_b);
          end
        end
      end
      if (w_frame_done) w_done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input bit wide, input logic [7:0] s, input logic [15:0] m,
                            input logic [127:0] d, input int nch, input int dw);
    logic [7:0] cnt, chk, b;
    logic [7:0] frame[$];
    cnt = 8'd0;
    for (int i = 0; i < nch; i++) if (m[i]) cnt++;
    frame.push_back(8'hA5);
    frame.push_back(s);
    frame.push_back(cnt);
    chk = s ^ cnt;
    for (int c = 0; c < nch; c++) begin
      if (m[c]) begin
        for (int k = 0; k < dw / 8; k++) begin
          b = d[c*dw + dw - 8*(k+1) +: 8];
          frame.push_back(b);
          chk ^= b;
        end
      end
    end
    frame.push_back(chk);
    foreach (frame[j]) begin
      if (wide) w_exp_q.push_back(frame[j]);
      else      exp_q.push_back(frame[j]);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_CH; i++) dram_data[i*DW +: DW] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_rd(input bit wide);
    @(posedge clk_100m); #1;
    if (wide) w_rd_done = 1'b1; else rd_done = 1'b1;
    @(posedge clk_100m); #1;
    if (wide) w_rd_done = 1'b0; else rd_done = 1'b0;
  endtask

  task automatic wait_done(input bit wide, input int target, input string name);
    int n;
    n = 0;
    while (((wide ? w_done_cnt : done_cnt) < target) && n < 5000) begin
      @(posedge clk_100m);
      n++;
    end
    repeat (2) @(posedge clk_100m);
    #1;
    vectors++;
    if ((wide ? w_done_cnt : done_cnt) != target) begin
      miscompares++;
      $display("FAIL %s_done: frame_done count %0d, required %0d", name,
               wide ? w_done_cnt : done_cnt, target);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_100m);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk_100m);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    vectors += 7;
    if (uart_en !== 1'b0)    begin miscompares++; $display("FAIL rst_uart_en: got %b required 0", uart_en); end
    if (uart_din !== 8'h00)  begin miscompares++; $display("FAIL rst_uart_din: got %02h required 00", uart_din); end
    if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL rst_frame_busy: got %b required 0", frame_busy); end
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    if (seq !== 8'h00)       begin miscompares++; $display("FAIL rst_seq: got %02h required 00", seq); end
    if (drop_cnt !== 8'h00)  begin miscompares++; $display("FAIL rst_drop_cnt: got %02h required 00", drop_cnt); end
    if (w_seq !== 8'h00)     begin miscompares++; $display("FAIL rst_w_seq: got %02h required 00", w_seq); end
  endtask

  task automatic test_all_channels();
    int trig_cyc, n0;
    dram_data = {NUM_CH{8'h55}};
    ch_mask   = 16'hFFFF;
    push_frame(1'b0, 8'h01, ch_mask, dram_data, NUM_CH, DW);
    n0 = en_cyc_q.size();
    @(posedge clk_100m); #1;
    rd_done = 1'b1;
    trig_cyc = cyc;
    @(posedge clk_100m); #1;
    rd_done = 1'b0;
    wait_done(1'b0, 1, "all_ch");
    vectors += 4;
    if (en_cyc_q.size() <= n0 || en_cyc_q[n0] - trig_cyc != 2) begin
      miscompares++;
      $display("FAIL latency: first uart_en %0d cycles after trigger, required 2",
               (en_cyc_q.size() > n0) ? en_cyc_q[n0] - trig_cyc : -1);
    end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL all_ch_left: %0d bytes outstanding, required 0", exp_q.size()); end
    if (seq !== 8'h01) begin miscompares++; $display("FAIL all_ch_seq: got %02h required 01", seq); end
    if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL all_ch_busy: got %b required 0", frame_busy); end
  endtask

  task automatic test_two_channels();
    rand_data();
    dram_data[7:0]  = 8'h12;
    dram_data[15:8] = 8'h34;
    ch_mask = 16'h0003;
    push_frame(1'b0, 8'h02, ch_mask, dram_data, NUM_CH, DW);
    pulse_rd(1'b0);
    wait_done(1'b0, 2, "two_ch");
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL two_ch_left: %0d bytes outstanding, required 0", exp_q.size()); end
    if (seq !== 8'h02) begin miscompares++; $display("FAIL two_ch_seq: got %02h required 02", seq); end
  endtask

  task automatic test_drops_and_level();
    int n0, n;
    rand_data();
    ch_mask = 16'h00F0;
    push_frame(1'b0, 8'h03, ch_mask, dram_data, NUM_CH, DW);
    n0 = en_cyc_q.size();
    pulse_rd(1'b0);
    n = 0;
    while (en_cyc_q.size() < n0 + 3 && n < 2000) begin @(posedge clk_100m); n++; end
    // Disturb the inputs mid-frame; the snapshot must not follow.
    rand_data();
    ch_mask = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 3; i++) pulse_rd(1'b0);
    wait_done(1'b0, 3, "drops");
    vectors += 3;
    if (drop_cnt !== 8'd3) begin miscompares++; $display("FAIL drop_cnt: got %0d required 3", drop_cnt); end
    if (seq !== 8'h03) begin miscompares++; $display("FAIL drops_seq: got %02h required 03", seq); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL drops_left: %0d bytes outstanding, required 0", exp_q.size()); end
    rand_data();
    ch_mask = 16'h0001;
    push_frame(1'b0, 8'h04, ch_mask, dram_data, NUM_CH, DW);
    @(posedge clk_100m); #1;
    rd_done = 1'b1;
    repeat (100) @(posedge clk_100m);
    #1 rd_done = 1'b0;
    wait_done(1'b0, 4, "level");
    repeat (40) @(posedge clk_100m);
    #1;
    vectors += 4;
    if (done_cnt != 4) begin miscompares++; $display("FAIL level_frames: got %0d frames required 4", done_cnt); end
    if (seq !== 8'h04) begin miscompares++; $display("FAIL level_seq: got %02h required 04", seq); end
    if (drop_cnt !== 8'd3) begin miscompares++; $display("FAIL level_drop_cnt: got %0d required 3", drop_cnt); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL level_left: %0d bytes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_busy_timeout();
    int n0, gap;
    stub_dead = 1'b1;
    rand_data();
    ch_mask = 16'h0005;
    push_frame(1'b0, 8'h05, ch_mask, dram_data, NUM_CH, DW);
    n0 = en_cyc_q.size();
    pulse_rd(1'b0);
    wait_done(1'b0, 5, "timeout");
    vectors++;
    if (en_cyc_q.size() - n0 != 6) begin
      miscompares++;
      $display("FAIL timeout_bytes: got %0d bytes required 6", en_cyc_q.size() - n0);
    end
    for (int i = n0 + 1; i < en_cyc_q.size(); i++) begin
      gap = en_cyc_q[i] - en_cyc_q[i-1];
      vectors++;
      if (gap < BUSY_TO + 1 || gap > BUSY_TO + 4) begin
        miscompares++;
        $display("FAIL timeout_gap: got %0d cycles required %0d..%0d", gap, BUSY_TO + 1, BUSY_TO + 4);
      end
    end
    stub_dead = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      rand_data();
      ch_mask = 16'($urandom_range(0, 65535));
      if (f == 1) ch_mask = 16'h0000;
      push_frame(1'b0, 8'(6 + f), ch_mask, dram_data, NUM_CH, DW);
      pulse_rd(1'b0);
      wait_done(1'b0, 6 + f, "b2b");
    end
    vectors += 2;
    if (seq !== 8'h08) begin miscompares++; $display("FAIL b2b_seq: got %02h required 08", seq); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_left: %0d bytes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_wide();
    w_dram_data = {16'h1234, 16'hABCD};
    w_ch_mask   = 2'b11;
    push_frame(1'b1, 8'h01, 16'(w_ch_mask), 128'(w_dram_data), 2, 16);
    pulse_rd(1'b1);
    wait_done(1'b1, 1, "wide1");
    w_dram_data = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
    w_ch_mask   = 2'b10;
    push_frame(1'b1, 8'h02, 16'(w_ch_mask), 128'(w_dram_data), 2, 16);
    pulse_rd(1'b1);
    wait_done(1'b1, 2, "wide2");
    vectors += 2;
    if (w_seq !== 8'h02) begin miscompares++; $display("FAIL wide_seq: got %02h required 02", w_seq); end
    if (w_exp_q.size() != 0) begin miscompares++; $display("FAIL wide_left: %0d bytes outstanding, required 0", w_exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int n0, n, d0;
    rand_data();
    ch_mask = 16'hFFFF;
    push_frame(1'b0, 8'h09, ch_mask, dram_data, NUM_CH, DW);
    n0 = en_cyc_q.size();
    pulse_rd(1'b0);
    n = 0;
    while (!(en_cyc_q.size() >= n0 + 5 && uart_busy) && n < 2000) begin
      @(posedge clk_100m); #1;
      n++;
    end
    vectors++;
    if (!(en_cyc_q.size() >= n0 + 5 && uart_busy)) begin
      miscompares++;
      $display("FAIL mid_reach: %0d bytes sent, busy=%b, required >=5 and 1", en_cyc_q.size() - n0, uart_busy);
    end
    @(posedge clk_100m);
    #2 rst_n = 1'b0;
    #1;
    vectors += 6;
    if (uart_en !== 1'b0)    begin miscompares++; $display("FAIL mid_uart_en: got %b required 0", uart_en); end
    if (uart_din !== 8'h00)  begin miscompares++; $display("FAIL mid_uart_din: got %02h required 00", uart_din); end
    if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL mid_frame_busy: got %b required 0", frame_busy); end
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL mid_frame_done: got %b required 0", frame_done); end
    if (seq !== 8'h00)       begin miscompares++; $display("FAIL mid_seq: got %02h required 00", seq); end
    if (drop_cnt !== 8'h00)  begin miscompares++; $display("FAIL mid_drop_cnt: got %02h required 00", drop_cnt); end
    exp_q.delete();
    w_exp_q.delete();
    repeat (3) @(posedge clk_100m);
    #2 rst_n = 1'b1;
    rand_data();
    ch_mask = 16'h0180;
    push_frame(1'b0, 8'h01, ch_mask, dram_data, NUM_CH, DW);
    d0 = done_cnt;
    pulse_rd(1'b0);
    wait_done(1'b0, d0 + 1, "after_rst");
    vectors += 2;
    if (seq !== 8'h01) begin miscompares++; $display("FAIL after_rst_seq: got %02h required 01", seq); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL after_rst_left: %0d bytes outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    rst_n       = 1'b0;
    rd_done     = 1'b0;
    w_rd_done   = 1'b0;
    dram_data   = '0;
    ch_mask     = '0;
    w_dram_data = '0;
    w_ch_mask   = '0;
    stub_dead   = 1'b0;
    test_reset();
    test_all_channels();
    test_two_channels();
    test_drops_and_level();
    test_busy_timeout();
    test_back_to_back();
    test_wide();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
